// File: rtl/apb_master_port.sv
// Single-outstanding APB initiator: turns a request/response command into one
// SETUP + ACCESS transfer, with wait states and an ACCESS-phase timeout.
module apb_master_port #(
  parameter int a_w  = 12,
  parameter int to_c = 16
) (
  input  logic           pclk,
  input  logic           presetn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [a_w-1:0] req_addr,
  input  logic [31:0]    req_wdata,
  output logic           resp_valid,
  output logic [31:0]    resp_rdata,
  output logic           resp_err,
  output logic [a_w-1:0] paddr,
  output logic [31:0]    pwdata,
  output logic           psel,
  output logic           penable,
  output logic           pwrite,
  input  logic [31:0]    prdata,
  input  logic           pready,
  output logic [1:0]     dbg_state
);

  // Handshake: a command transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE. resp_valid is a one-cycle pulse with no
  // backpressure, so the consumer must take it in that cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam bit TO_EN = (to_c > 0);
  localparam int CNT_W = (to_c > 0) ? $clog2(to_c + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(to_c - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [a_w-1:0]   paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write;
          paddr_d   = req_addr;
          if (req_write) pwdata_d = req_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d      = IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = pwrite_q ? 32'h0 : prdata;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Last allowed ACCESS cycle ended without pready: abandon the transfer.
          state_d      = IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign dbg_state  = state_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_apb_master_port.sv
// Directed bench for apb_master_port: vector table of single transfers, a
// back-to-back memory-slave run with an expected queue, and a reset mid-ACCESS.
module tb_apb_master_port;

  localparam int A_W  = 12;
  localparam int TO_C = 16;

  // ---------------- clock / reset ----------------
  logic pclk;
  logic presetn;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [A_W-1:0] req_addr;
  logic [31:0]    req_wdata;
  logic           resp_valid;
  logic [31:0]    resp_rdata;
  logic           resp_err;
  logic [A_W-1:0] paddr;
  logic [31:0]    pwdata;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [31:0]    prdata;
  logic           pready;
  logic [1:0]     dbg_state;

  apb_master_port #(.a_w(A_W), .to_c(TO_C)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .prdata     (prdata),
    .pready     (pready),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pwdata;
  logic [31:0] mem [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  // Entered at a negedge with the DUT in IDLE; returns at the negedge of the
  // response cycle, so consecutive calls run back to back.
  task automatic do_xfer(input logic wr, input logic [A_W-1:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] sdata, input logic use_mem,
                         input logic noise, input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_psel);
    int psel_cnt;
    psel_cnt = 0;
    chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    pready    = 1'b0;
    if (wr) exp_pwdata = wdata;
    @(negedge pclk);
    if (noise) begin
      req_valid = 1'b1;
      req_write = ~wr;
      req_addr  = ~addr;
      req_wdata = ~wdata;
    end else begin
      req_valid = 1'b0;
    end
    if (psel) psel_cnt++;
    chk("setup_penable",    {31'h0, penable},    32'h0);
    chk("setup_paddr",      {20'h0, paddr},      {20'h0, addr});
    chk("setup_pwrite",     {31'h0, pwrite},     {31'h0, wr});
    chk("setup_pwdata",     pwdata,              exp_pwdata);
    chk("setup_req_ready",  {31'h0, req_ready},  32'h0);
    chk("setup_resp_valid", {31'h0, resp_valid}, 32'h0);
    pready = (waits == 0);  // must be ignored while in SETUP
    for (int k = 0; (k <= waits) && (k < TO_C); k++) begin
      @(negedge pclk);
      if (psel) psel_cnt++;
      chk("access_penable", {31'h0, penable}, 32'h1);
      chk("access_paddr",   {20'h0, paddr},   {20'h0, addr});
      chk("access_pwrite",  {31'h0, pwrite},  {31'h0, wr});
      chk("access_pwdata",  pwdata,           exp_pwdata);
      pready = (k == waits);
      prdata = use_mem ? mem[paddr] : sdata;
      if (use_mem && pready && pwrite) mem[paddr] = pwdata;
    end
    @(negedge pclk);
    pready    = 1'b0;
    req_valid = 1'b0;
    chk("resp_valid",      {31'h0, resp_valid}, 32'h1);
    chk("resp_err",        {31'h0, resp_err},   {31'h0, exp_err});
    chk("resp_rdata",      resp_rdata,          exp_rdata);
    chk("resp_psel",       {31'h0, psel},       32'h0);
    chk("resp_penable",    {31'h0, penable},    32'h0);
    chk("resp_paddr_hold", {20'h0, paddr},      {20'h0, addr});
    chk("psel_cycles",     32'(psel_cnt),       32'(exp_psel));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           wr;
    logic [A_W-1:0] addr;
    logic [31:0]    wdata;
    int             waits;
    logic [31:0]    sdata;
    logic           noise;
    logic           exp_err;
    logic [31:0]    exp_rdata;
    int             exp_psel;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [A_W-1:0] addrs[20];
    logic [31:0]    wd;
    logic [31:0]    ed;

    vecs[0] = '{1'b1, 12'h3F4, 32'hDEADBEEF,  0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000,  2};
    vecs[1] = '{1'b0, 12'h804, 32'h00000000,  3, 32'h12345678, 1'b0, 1'b0, 32'h12345678,  5};
    vecs[2] = '{1'b1, 12'h010, 32'hCAFEF00D,  1, 32'h00000000, 1'b0, 1'b0, 32'h00000000,  3};
    vecs[3] = '{1'b0, 12'hFFC, 32'h00000000, 15, 32'h0BADC0DE, 1'b0, 1'b0, 32'h0BADC0DE, 17};
    vecs[4] = '{1'b0, 12'h123, 32'h00000000, 40, 32'h5555AAAA, 1'b0, 1'b1, 32'h00000000, 17};
    vecs[5] = '{1'b1, 12'h7FF, 32'hA5A5A5A5,  2, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000,  4};
    vecs[6] = '{1'b0, 12'h3F4, 32'h00000000,  0, 32'h00000001, 1'b1, 1'b0, 32'h00000001,  2};

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    presetn    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = 32'h0;
    prdata     = 32'h0;
    pready     = 1'b0;
    exp_pwdata = 32'h0;

    // reset values
    repeat (2) @(negedge pclk);
    chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst_psel",       {31'h0, psel},       32'h0);
    chk("rst_penable",    {31'h0, penable},    32'h0);
    chk("rst_pwrite",     {31'h0, pwrite},     32'h0);
    chk("rst_paddr",      {20'h0, paddr},      32'h0);
    chk("rst_pwdata",     pwdata,              32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
    chk("rst_resp_rdata", resp_rdata,          32'h0);
    presetn = 1'b1;
    @(negedge pclk);

    // table: zero-wait, wait states, last-cycle pready, timeout, requests outside IDLE
    for (int i = 0; i < 7; i++)
      do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].sdata,
              1'b0, vecs[i].noise, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_psel);

    // back-to-back writes then reads through a zero-wait memory slave
    for (int i = 0; i < 20; i++) begin
      addrs[i] = A_W'(i * 204 + $urandom_range(0, 50) * 4);
      wd = $urandom;
      exp_q.push_back(wd);
      do_xfer(1'b1, addrs[i], wd, 0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2);
    end
    for (int i = 0; i < 20; i++) begin
      ed = exp_q.pop_front();
      do_xfer(1'b0, addrs[i], 32'h0, 0, 32'h0, 1'b1, 1'b0, 1'b0, ed, 2);
    end

    // reset asserted mid-ACCESS
    @(negedge pclk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h555;
    req_wdata = 32'h11112222;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    chk("rst_mid_in_access", {31'h0, penable}, 32'h1);
    #2 presetn = 1'b0;
    #1;
    chk("rst_mid_psel",       {31'h0, psel},       32'h0);
    chk("rst_mid_penable",    {31'h0, penable},    32'h0);
    chk("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mid_paddr",      {20'h0, paddr},      32'h0);
    chk("rst_mid_pwdata",     pwdata,              32'h0);
    chk("rst_mid_req_ready",  {31'h0, req_ready},  32'h1);
    exp_pwdata = 32'h0;
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("rst_mid_no_resp",   {31'h0, resp_valid}, 32'h0);
      chk("rst_mid_ready_rel", {31'h0, req_ready},  32'h1);
    end
    do_xfer(1'b0, 12'h804, 32'h0, 1, 32'h87654321, 1'b0, 1'b0, 1'b0, 32'h87654321, 3);

    @(negedge pclk);
    chk("final_resp_drop", {31'h0, resp_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master_port.md
# apb_master_port

Single-outstanding APB initiator that converts a simple request/response command interface into APB SETUP/ACCESS transfers. It sits upstream of `apb_router`, driving that router's master-side port (`paddr`, `pwdata`, `psel`, `penable`, `pwrite`, `prdata`, `pready`). It also provides wait-state handling and a bus timeout that returns an error response.

## Interface
- `a_w`, 12, APB address width
- `to_c`, 16, maximum ACCESS-phase cycles before timeout; 0 disables the timeout
- `pclk`  in  1  clock; single clock domain
- `presetn`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  command request
- `req_ready`  out  1  block can accept a command
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  a_w  transfer address
- `req_wdata`  in  32  write data
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  read data; 0 for writes and errors
- `resp_err`  out  1  transfer terminated by timeout
- `paddr`  out  a_w  APB address
- `pwdata`  out  32  APB write data
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `prdata`  in  32  APB read data
- `pready`  in  1  APB ready

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - `req_ready`=1.
  - `req_valid` at a posedge: capture address, direction and write data; go to SETUP.
- **SETUP**
  - `psel`=1, `penable`=0, with `paddr`/`pwrite` (and `pwdata` on writes) valid.
  - Unconditionally go to ACCESS.
  - `req_ready`=0.
- **ACCESS**
  - `psel`=1, `penable`=1.
  - `pready`=1 at a posedge completes the transfer:
    - reads register `prdata` into `resp_rdata`;
    - `resp_valid`=1 and `resp_err`=0 in the following cycle;
    - go to IDLE.
  - `pready`=0 extends ACCESS (wait state); the timeout counter increments.
- **Timeout**
  - The counter clears on SETUP→ACCESS.
  - If `pready`=0 at the posedge that ends the `to_c`-th ACCESS cycle:
    - drop `psel`/`penable`;
    - `resp_valid`=1, `resp_err`=1, `resp_rdata`=0;
    - go to IDLE.
  - Counter width is $clog2(to_c+1).
- **Hold rules**
  - `paddr`, `pwrite` and `pwdata` are stable from SETUP through the end of ACCESS.
  - After completion, they hold their last values.
  - `pwdata` is loaded only on write commands.
- **No response backpressure:** `resp_valid` is a single-cycle pulse, and the consumer must sample it.
- **No queuing:** exactly one outstanding transfer; `req_valid` is ignored outside IDLE.
- **Reset**
  - Asserting `presetn` mid-transfer immediately forces IDLE and zeroes all APB outputs and the response outputs.
  - The in-flight transfer is dropped, and no response is generated.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, `psel`=`penable`=`pwrite`=0, `paddr`=0, `pwdata`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- **Command acceptance:** accepted at edge E0; SETUP is cycle E0–E1; ACCESS starts at E1.
- **Zero-wait transfer:**
  - `pready`=1 sampled at E2;
  - `resp_valid` high during E2–E3;
  - `req_ready`=1 during E2–E3, so a new command can be accepted at E3.
- **Throughput:** 3 cycles per zero-wait transfer; each wait state adds 1 cycle.
- **Timeout:**
  - `resp_err` pulse starts `to_c`+1 cycles after SETUP entry;
  - `psel` is high for exactly `to_c`+1 cycles (1 SETUP + `to_c` ACCESS).
- **Output registers:** all APB and response outputs are registered; `req_ready` is decoded from state (state==IDLE).
- **`pready` outside ACCESS:** ignored.

## Test plan
- **Zero-wait write:**
  - stimulus: `req_addr`=0x3F4, `req_wdata`=0xDEADBEEF, `pready` tied 1;
  - response: `psel` high 2 cycles, `penable` high in the 2nd, `pwrite`=1, `paddr`=0x3F4, `pwdata`=0xDEADBEEF;
  - then `resp_valid`=1 with `resp_err`=0 and `resp_rdata`=0.
- **Read with 3 wait states:**
  - stimulus: addr 0x804, slave drives `prdata`=0x12345678 and `pready` on the 4th ACCESS cycle;
  - response: `resp_rdata`=0x12345678, `resp_err`=0, `paddr` stable throughout.
- **Timeout:**
  - stimulus: `to_c`=16, `pready` held 0;
  - response: `psel` high 17 cycles, then `resp_valid`=1, `resp_err`=1, `resp_rdata`=0;
  - the next command is accepted normally.
- **Back-to-back traffic:**
  - stimulus: 20 random word-aligned writes to 0x000–0xFFF through `apb_router` with 4 memory slaves, followed by 20 reads of the same addresses;
  - response: every read returns its written data, and each zero-wait transfer takes 3 cycles.
- **Request outside IDLE:** asserting `req_valid` during SETUP/ACCESS causes no capture or corruption; the command is taken only when `req_ready`=1.
- **Reset mid-ACCESS:**
  - stimulus: `presetn` low while in ACCESS;
  - response: `psel`/`penable`/`resp_valid` drop to 0 without waiting for a clock, no response is issued, and `req_ready`=1 after release.
